// File: rtl/ksa_shuffle_engine.sv
// RC4 key-scheduling shuffle (KSA loop 2) over an external single-port S memory.
// Optional: SHUFFLE_SKIP_SELF_SWAP_EN skips both writes when the new j equals i.
module ksa_shuffle_engine #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [8*KEY_BYTES-1:0]           secret_key,
  input  logic [$clog2(KEY_BYTES+1)-1:0]   key_len,
  input  logic [ADDR_W-1:0]                mem_rdata,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [ADDR_W-1:0]                mem_wdata,
  output logic                             mem_we,
  output logic                             ready,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned KL_W = $clog2(KEY_BYTES + 1);
  localparam int unsigned CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_I, S_WAIT_I, S_CALC_J, S_RD_J,
    S_WAIT_J, S_WR_I, S_WR_J, S_NEXT, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d;
  logic [ADDR_W-1:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [KL_W-1:0]        kidx_q, kidx_d, klen_q, klen_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             kbyte8;
  logic [ADDR_W-1:0]      kbyte, j_new;
  logic [KL_W:0]          klen_ext;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
  logic                   self_q, self_d;
`endif

  always_comb begin
    kbyte8 = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KL_W'(k)) kbyte8 = key_q[8*(KEY_BYTES-1-k) +: 8];
    end
    if (klen_q == '0) kbyte8 = '0;
  end

  assign kbyte    = ADDR_W'(kbyte8);
  assign j_new    = j_q + si_q + kbyte;
  assign klen_ext = {1'b0, key_len};

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign busy      = !(ready || done);
  assign mem_we    = (state_q == S_WR_I) || (state_q == S_WR_J);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    kidx_d  = kidx_q;
    klen_d  = klen_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
    self_d  = self_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = secret_key;
          klen_d  = (klen_ext > (KL_W+1)'(KEY_BYTES)) ? KL_W'(KEY_BYTES) : key_len;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = S_RD_I;
        end
      end
      S_RD_I: begin
        addr_d  = i_q;
        cnt_d   = '0;
        state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        if (cnt_q == CNT_LAST) begin
          si_d    = mem_rdata;
          state_d = S_CALC_J;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CALC_J: begin
        j_d     = j_new;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
        self_d  = (j_new == i_q);
`endif
        state_d = S_RD_J;
      end
      S_RD_J: begin
        addr_d  = j_q;
        cnt_d   = '0;
        state_d = S_WAIT_J;
      end
      S_WAIT_J: begin
        if (cnt_q == CNT_LAST) begin
          // S[j] goes straight into the write-data register for the WR_I store.
          wdata_d = mem_rdata;
          addr_d  = i_q;
          state_d = S_WR_I;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
          if (self_q) state_d = S_NEXT;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_I: begin
        addr_d  = j_q;
        wdata_d = si_q;
        state_d = S_WR_J;
      end
      S_WR_J: state_d = S_NEXT;
      S_NEXT: begin
        if (klen_q != '0) kidx_d = (kidx_q + KL_W'(1) == klen_q) ? '0 : kidx_q + KL_W'(1);
        if (i_q == '1) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_I;
        end
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && busy) state_d = S_IDLE;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      kidx_q  <= '0;
      klen_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
      self_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      kidx_q  <= kidx_d;
      klen_q  <= klen_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
      self_q  <= self_d;
`endif
    end
  end

endmodule

// File: tb/tb_ksa_shuffle_engine.sv
// Scoreboard bench for ksa_shuffle_engine: a software KSA queues expected writes,
// a monitor pops them on every mem_we; timing, abort and async reset are checked directly.
module tb_ksa_shuffle_engine;

  localparam int AW = 8;
  localparam int KB = 3;
  localparam int RL = 2;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          CLOCK_50, reset, start, abort, mem_we, ready, busy, done;
  logic [23:0]   secret_key;
  logic [1:0]    key_len;
  logic [7:0]    mem_rdata, mem_addr, mem_wdata;

  ksa_shuffle_engine #(.ADDR_W(AW), .KEY_BYTES(KB), .RD_LAT(RL)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
    .secret_key(secret_key), .key_len(key_len), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ready(ready), .busy(busy), .done(done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // External S memory with a two-cycle read (one register stage after the address register).
  logic [7:0] mem [256];
  logic [7:0] rd_pipe;
  logic       mem_init_req;
  always @(posedge CLOCK_50) begin
    if (mem_init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd_pipe <= mem[mem_addr];
  end
  assign mem_rdata = rd_pipe;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] seen_q[$];
  logic [7:0]  sm [256];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  wr_t mon_e;
  always @(negedge CLOCK_50) begin
    if (!reset && mem_we) begin
      seen_q.push_back({mem_addr, mem_wdata});
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        check("wr_data", 32'(mem_wdata), 32'(mon_e.d));
      end
    end
  end

  task automatic model_run(input logic [23:0] key, input int kl, input int iters, output int cyc);
    int j, kidx;
    logic [7:0] kb, si, sj;
    wr_t w;
    j = 0; kidx = 0; cyc = 0;
    for (int i = 0; i < iters; i++) begin
      kb = (kl == 0) ? 8'h00 : key[23-8*kidx -: 8];
      j  = (j + int'(sm[i]) + int'(kb)) % 256;
      si = sm[i];
      sj = sm[j];
      if (SKIP && j == i) begin
        cyc += 4 + 2*RL;
      end else begin
        cyc += 6 + 2*RL;
        w.a = 8'(i); w.d = sj; exp_q.push_back(w);
        w.a = 8'(j); w.d = si; exp_q.push_back(w);
      end
      sm[i] = sj;
      sm[j] = si;
      if (kl != 0) kidx = (kidx + 1 == kl) ? 0 : kidx + 1;
    end
  endtask

  task automatic prep();
    @(negedge CLOCK_50) mem_init_req = 1'b1;
    @(negedge CLOCK_50) mem_init_req = 1'b0;
    for (int k = 0; k < 256; k++) sm[k] = 8'(k);
    seen_q.delete();
  endtask

  task automatic start_run(input logic [23:0] key, input logic [1:0] kl, input bit hold);
    @(negedge CLOCK_50);
    secret_key = key; key_len = kl; start = 1'b1;
    @(posedge CLOCK_50);
    if (!hold) #1 start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string nm);
    int cnt;
    cnt = 0;
    while (cnt < 6000) begin
      @(posedge CLOCK_50); #1;
      cnt++;
      if (cnt == 1) check({nm, "_busy"}, {ready, busy}, 2'b01);
      if (done) break;
    end
    check(nm, cnt, exp_cyc);
  endtask

  function automatic int s_mismatch();
    int m = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== sm[k]) m++;
    return m;
  endfunction

  logic [23:0] vec_key [4] = '{24'h4B6579, 24'hFFFFFF, 24'h01AABB, 24'h123456};
  logic [1:0]  vec_kl  [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
  logic [7:0]  vec_j0  [4] = '{8'h4B, 8'h00, 8'h01, 8'h12};

  initial begin
    int cyc, w;
    reset = 1'b0; start = 1'b0; abort = 1'b0; secret_key = '0; key_len = '0; mem_init_req = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_flags", {ready, busy, done, mem_we}, 4'b1000);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 16'h0000);
    @(negedge CLOCK_50) reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      prep();
      model_run(vec_key[v], int'(vec_kl[v]), 256, cyc);
      start_run(vec_key[v], vec_kl[v], v == 0);
      wait_done(SKIP ? cyc : 2560, "start_to_done");
      if (!(SKIP && vec_j0[v] == 8'h00)) begin
        check("first_wr_i", (seen_q.size() > 0) ? 32'(seen_q[0]) : 32'hDEAD, {16'h0, 8'h00, vec_j0[v]});
        check("first_wr_j", (seen_q.size() > 1) ? 32'(seen_q[1]) : 32'hDEAD, {16'h0, vec_j0[v], 8'h00});
      end
      if (v == 0) begin
        repeat (3) begin
          @(posedge CLOCK_50); #1;
          check("done_held", {done, ready}, 2'b10);
        end
        @(negedge CLOCK_50) start = 1'b0;
      end
      @(posedge CLOCK_50); #1;
      check("ready_after_done", {ready, done, busy}, 3'b100);
      check("final_S_mismatches", s_mismatch(), 0);
      check("queue_drained", exp_q.size(), 0);
    end

    // Abort during WAIT_J of iteration 5 (cycle 56 after the start edge).
    prep();
    model_run(24'h4B6579, 3, 5, cyc);
    start_run(24'h4B6579, 2'd3, 1'b0);
    repeat (55) @(posedge CLOCK_50);
    #1 abort = 1'b1;
    @(posedge CLOCK_50);
    #1 abort = 1'b0;
    check("abort_ready", {ready, busy, mem_we}, 3'b100);
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("abort_S_mismatches", s_mismatch(), 0);
    check("abort_queue_drained", exp_q.size(), 0);

    prep();
    model_run(24'h4B6579, 3, 256, cyc);
    start_run(24'h4B6579, 2'd3, 1'b0);
    wait_done(SKIP ? cyc : 2560, "restart_to_done");
    check("restart_S_mismatches", s_mismatch(), 0);
    @(posedge CLOCK_50); #1;

    // Asynchronous reset while WR_I is driving the first write.
    prep();
    model_run(24'h4B6579, 3, 256, cyc);
    start_run(24'h4B6579, 2'd3, 1'b0);
    w = 0;
    while (w < 100) begin
      @(negedge CLOCK_50);
      w++;
      if (mem_we) break;
    end
    check("reset_test_we_seen", mem_we, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_flags", {ready, busy, done, mem_we}, 4'b1000);
    check("async_rst_addr_wdata", {mem_addr, mem_wdata}, 16'h0000);
    exp_q.delete();
    @(negedge CLOCK_50) reset = 1'b0;
    repeat (20) @(posedge CLOCK_50);
    #1;
    check("post_reset_idle", {ready, busy, done, mem_we}, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
